// File: rtl/regfile_sb.sv
`default_nettype none
// ============================================================================
//  Module   : regfile_sb
//  Purpose  : Multi-read, dual-write integer register file with same-cycle
//             write-to-read forwarding, a per-register busy scoreboard and a
//             post-reset clear sequencer that zeroes every entry before the
//             file reports ready.
//  Revision : 1.0 - initial release
// ============================================================================
module regfile_sb #(
  parameter int XLEN     = 32,
  parameter int NREG     = 32,
  parameter int NRD      = 2,
  parameter int ZERO_REG = 1,
  localparam int AW      = $clog2(NREG)
) (
  input  logic                clk,
  input  logic                rst,
  output logic                ready,
  // writeback lane 0
  input  logic                we0,
  input  logic [AW-1:0]       wa0,
  input  logic [XLEN-1:0]     wd0,
  // writeback lane 1
  input  logic                we1,
  input  logic [AW-1:0]       wa1,
  input  logic [XLEN-1:0]     wd1,
  // read ports, packed port-major
  input  logic [NRD*AW-1:0]   ra,
  output logic [NRD*XLEN-1:0] rd,
  output logic [NRD-1:0]      rbusy,
  // issue
  input  logic                iss_valid,
  input  logic [AW-1:0]       iss_rd
);

  localparam bit            ZR       = (ZERO_REG != 0);
  localparam logic [AW-1:0] LAST_REG = AW'(NREG - 1);

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [AW-1:0]     clr_cnt;
  logic [AW-1:0]     clr_cnt_nxt;
  logic              run;

  logic [XLEN-1:0]   mem [NREG];
  logic [NREG-1:0]   busy;
  logic [NREG-1:0]   busy_nxt;

  logic              wen0;
  logic              wen1;
  logic              iss_en;

  assign run   = (state == ST_RUN);
  assign ready = run;

  // Writes to the hard-wired zero register are dropped; nothing is accepted
  // until the clear sequence has finished.
  assign wen0   = run && we0 && !(ZR && (wa0 == '0));
  assign wen1   = run && we1 && !(ZR && (wa1 == '0));
  assign iss_en = run && iss_valid && !(ZR && (iss_rd == '0));

  // Next-state logic: walk the counter through every register, then run.
  always_comb begin
    state_nxt   = state;
    clr_cnt_nxt = clr_cnt;
    case (state)
      ST_CLEAR: begin
        clr_cnt_nxt = clr_cnt + 1'b1;
        if (clr_cnt == LAST_REG) begin
          state_nxt = ST_RUN;
        end
      end
      ST_RUN: begin
        state_nxt = ST_RUN;
      end
      default: begin
        state_nxt = ST_CLEAR;
      end
    endcase
  end

  // State register; reset always restarts the clear sweep from entry 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_CLEAR;
      clr_cnt <= '0;
    end else begin
      state   <= state_nxt;
      clr_cnt <= clr_cnt_nxt;
    end
  end

  // Storage: zero one entry per cycle while clearing, otherwise retire both
  // lanes. Lane 1 is written last so it wins an address collision.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (!run) begin
        mem[clr_cnt] <= '0;
      end else begin
        if (wen0) begin
          mem[wa0] <= wd0;
        end
        if (wen1) begin
          mem[wa1] <= wd1;
        end
      end
    end
  end

  // Scoreboard update: writebacks clear, then issue sets, so a new producer
  // issued in the same cycle as the old one retires keeps the register busy.
  always_comb begin
    busy_nxt = busy;
    if (wen0 || (run && we0)) begin
      busy_nxt[wa0] = 1'b0;
    end
    if (wen1 || (run && we1)) begin
      busy_nxt[wa1] = 1'b0;
    end
    if (iss_en) begin
      busy_nxt[iss_rd] = 1'b1;
    end
  end

  // Scoreboard register.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy <= '0;
    end else begin
      busy <= busy_nxt;
    end
  end

  // Read ports: zero register first, then lane 1 bypass, lane 0 bypass and
  // finally the stored value. A pending write also hides the busy flag since
  // the reader picks the value straight off the bypass.
  generate
    for (genvar i = 0; i < NRD; i++) begin : g_rd
      logic [AW-1:0]   addr;
      logic [XLEN-1:0] data;
      logic            bsy;

      assign addr = ra[i*AW +: AW];

      // Per-port operand select and busy lookup.
      always_comb begin
        data = mem[addr];
        bsy  = busy[addr];
        if (!run) begin
          data = '0;
          bsy  = 1'b0;
        end else if (ZR && (addr == '0)) begin
          data = '0;
          bsy  = 1'b0;
        end else if (we1 && (wa1 == addr)) begin
          data = wd1;
          bsy  = 1'b0;
        end else if (we0 && (wa0 == addr)) begin
          data = wd0;
          bsy  = 1'b0;
        end
      end

      assign rd[i*XLEN +: XLEN] = data;
      assign rbusy[i]           = bsy;
    end
  endgenerate

endmodule
`default_nettype wire

// File: tb/tb_regfile_sb.sv
`default_nettype none
// ============================================================================
//  Module   : tb_regfile_sb
//  Purpose  : Self-checking bench for regfile_sb: directed scenarios with
//             literal expectations plus randomized traffic compared every
//             cycle against a behavioural array model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_regfile_sb;

  localparam int XLEN = 32;
  localparam int NREG = 32;
  localparam int NRD  = 2;
  localparam int AW   = 5;

  logic                clk = 1'b0;
  logic                rst;
  logic                ready;
  logic                we0, we1;
  logic [AW-1:0]       wa0, wa1;
  logic [XLEN-1:0]     wd0, wd1;
  logic [NRD*AW-1:0]   ra;
  logic [NRD*XLEN-1:0] rd;
  logic [NRD-1:0]      rbusy;
  logic                iss_valid;
  logic [AW-1:0]       iss_rd;

  int checks = 0;
  int errors = 0;

  // Behavioural model: plain arrays plus a count of reset-free cycles.
  logic [XLEN-1:0] m_mem [NREG];
  bit              m_busy [NREG];
  int              m_low   = 0;
  bit              m_valid = 1'b0;

  regfile_sb #(.XLEN(XLEN), .NREG(NREG), .NRD(NRD), .ZERO_REG(1)) dut (
    .clk(clk), .rst(rst), .ready(ready),
    .we0(we0), .wa0(wa0), .wd0(wd0),
    .we1(we1), .wa1(wa1), .wd1(wd1),
    .ra(ra), .rd(rd), .rbusy(rbusy),
    .iss_valid(iss_valid), .iss_rd(iss_rd)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  function automatic logic m_ready();
    return m_valid && (m_low >= NREG);
  endfunction

  function automatic logic [XLEN-1:0] exp_rd(input logic [AW-1:0] a);
    if (!m_ready() || a == 0) return '0;
    if (we1 && wa1 == a) return wd1;
    if (we0 && wa0 == a) return wd0;
    return m_mem[a];
  endfunction

  function automatic logic exp_busy(input logic [AW-1:0] a);
    if (!m_ready() || a == 0) return 1'b0;
    if ((we1 && wa1 == a) || (we0 && wa0 == a)) return 1'b0;
    return m_busy[a];
  endfunction

  task automatic check(input string name, input logic [XLEN-1:0] got, input logic [XLEN-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic compare_all();
    logic [AW-1:0] a;
    if (!m_valid) return;
    check("ready", XLEN'(ready), XLEN'(m_ready()));
    for (int p = 0; p < NRD; p++) begin
      a = ra[p*AW +: AW];
      check($sformatf("rd%0d(r%0d)", p, a), rd[p*XLEN +: XLEN], exp_rd(a));
      check($sformatf("rbusy%0d(r%0d)", p, a), XLEN'(rbusy[p]), XLEN'(exp_busy(a)));
    end
  endtask

  task automatic model_update();
    if (rst) begin
      m_valid = 1'b1;
      m_low   = 0;
      for (int r = 0; r < NREG; r++) begin
        m_mem[r]  = '0;
        m_busy[r] = 1'b0;
      end
    end else if (m_valid) begin
      if (m_low < NREG) begin
        m_low++;
      end else begin
        if (we0 && wa0 != 0) m_mem[wa0] = wd0;
        if (we1 && wa1 != 0) m_mem[wa1] = wd1;
        if (we0) m_busy[wa0] = 1'b0;
        if (we1) m_busy[wa1] = 1'b0;
        if (iss_valid && iss_rd != 0) m_busy[iss_rd] = 1'b1;
      end
    end
  endtask

  // One clock: compare on the falling edge, advance the model on the rising
  // edge, then hand control back 1 time unit later for new stimulus.
  task automatic tick();
    @(negedge clk);
    compare_all();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic idle_inputs();
    we0 = 1'b0; wa0 = '0; wd0 = '0;
    we1 = 1'b0; wa1 = '0; wd1 = '0;
    iss_valid = 1'b0; iss_rd = '0;
  endtask

  task automatic count_to_ready(input string name);
    int n;
    n = 0;
    do begin
      tick();
      n++;
    end while (!ready && n < 100);
    check(name, XLEN'(n), 32);
  endtask

  initial begin
    rst = 1'b1;
    ra  = '0;
    idle_inputs();
    tick();
    tick();
    rst = 1'b0;
    count_to_ready("initial_clear_cycles");

    // Preload r5, then pulse reset and confirm it reads back cleared.
    we0 = 1'b1; wa0 = 5'd5; wd0 = 32'hDEADBEEF;
    tick();
    idle_inputs();
    ra = {5'd0, 5'd5};
    #1 check("preload_r5", rd[XLEN-1:0], 32'hDEADBEEF);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    count_to_ready("clear_after_pulse");
    ra = {5'd5, 5'd5};
    #1 check("r5_after_clear", rd[XLEN-1:0], 32'h0);
    for (int r = 0; r < NREG; r++) begin
      ra = {AW'(r), AW'(r)};
      #1 check($sformatf("idle_busy_r%0d", r), XLEN'(rbusy), 32'h0);
      tick();
    end

    // Forwarding then stored value.
    we0 = 1'b1; wa0 = 5'd7; wd0 = 32'h11; ra = {5'd0, 5'd7};
    #1 check("fwd_same_cycle", rd[XLEN-1:0], 32'h11);
    tick();
    idle_inputs();
    #1 check("fwd_stored", rd[XLEN-1:0], 32'h11);

    // Lane collision: lane 1 wins.
    we0 = 1'b1; wa0 = 5'd3; wd0 = 32'hAAAA;
    we1 = 1'b1; wa1 = 5'd3; wd1 = 32'h5555;
    ra  = {5'd3, 5'd3};
    #1 check("collide_comb", rd[XLEN-1:0], 32'h5555);
    tick();
    idle_inputs();
    #1 check("collide_stored", rd[2*XLEN-1:XLEN], 32'h5555);

    // Zero register ignores writes and issues.
    we0 = 1'b1; wa0 = 5'd0; wd0 = 32'hFFFFFFFF; ra = {5'd0, 5'd0};
    #1 check("r0_fwd", rd[XLEN-1:0], 32'h0);
    tick();
    idle_inputs();
    iss_valid = 1'b1; iss_rd = 5'd0;
    tick();
    idle_inputs();
    #1 check("r0_busy", XLEN'(rbusy), 32'h0);
    check("r0_data", rd[XLEN-1:0], 32'h0);

    // Scoreboard race: set wins over a same-cycle writeback.
    ra = {5'd9, 5'd9};
    iss_valid = 1'b1; iss_rd = 5'd9;
    tick();
    idle_inputs();
    #1 check("issue_busy", XLEN'(rbusy[0]), 32'h1);
    iss_valid = 1'b1; iss_rd = 5'd9;
    we1 = 1'b1; wa1 = 5'd9; wd1 = 32'h99;
    #1 check("race_fwd_busy", XLEN'(rbusy[0]), 32'h0);
    check("race_fwd_data", rd[XLEN-1:0], 32'h99);
    tick();
    idle_inputs();
    #1 check("race_set_wins", XLEN'(rbusy[0]), 32'h1);
    we0 = 1'b1; wa0 = 5'd9; wd0 = 32'h1234;
    tick();
    idle_inputs();
    #1 check("retire_clears", XLEN'(rbusy[0]), 32'h0);

    // Reset re-asserted in the middle of the clear sweep.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    repeat (10) tick();
    check("mid_clear_not_ready", XLEN'(ready), 32'h0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    count_to_ready("clear_after_mid_reset");

    // Randomized traffic, including rare resets and requests during clear.
    for (int c = 0; c < 3000; c++) begin
      rst       = ($urandom_range(0, 399) == 0);
      we0       = $urandom_range(0, 1) == 1;
      we1       = $urandom_range(0, 1) == 1;
      wa0       = AW'($urandom);
      wa1       = ($urandom_range(0, 7) == 0) ? wa0 : AW'($urandom);
      wd0       = $urandom;
      wd1       = $urandom;
      iss_valid = $urandom_range(0, 2) == 0;
      iss_rd    = ($urandom_range(0, 5) == 0) ? wa1 : AW'($urandom);
      for (int p = 0; p < NRD; p++) begin
        case ($urandom_range(0, 3))
          0:       ra[p*AW +: AW] = wa0;
          1:       ra[p*AW +: AW] = wa1;
          default: ra[p*AW +: AW] = AW'($urandom);
        endcase
      end
      tick();
    end
    rst = 1'b0;
    idle_inputs();
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
